// File: rtl/mipsfpga_sevenseg_pkg.sv
// Shared constants for the seven-segment capture block: active-low glyph patterns
// (bit6=a .. bit0=g) and the stability counter width helper.
package mipsfpga_sevenseg_pkg;

  localparam logic [6:0] SEG_0     = 7'b000_0001;
  localparam logic [6:0] SEG_1     = 7'b100_1111;
  localparam logic [6:0] SEG_2     = 7'b001_0010;
  localparam logic [6:0] SEG_3     = 7'b000_0110;
  localparam logic [6:0] SEG_4     = 7'b100_1100;
  localparam logic [6:0] SEG_5     = 7'b010_0100;
  localparam logic [6:0] SEG_6     = 7'b010_0000;
  localparam logic [6:0] SEG_7     = 7'b000_1111;
  localparam logic [6:0] SEG_8     = 7'b000_0000;
  localparam logic [6:0] SEG_9     = 7'b000_1100;
  localparam logic [6:0] SEG_A     = 7'b000_1000;
  localparam logic [6:0] SEG_B     = 7'b110_0000;
  localparam logic [6:0] SEG_C     = 7'b111_0010;
  localparam logic [6:0] SEG_D     = 7'b100_0010;
  localparam logic [6:0] SEG_E     = 7'b011_0000;
  localparam logic [6:0] SEG_F     = 7'b011_1000;
  localparam logic [6:0] SEG_BLANK = 7'b111_1111;

  // Counter must be able to hold the saturation value STABLE_CYCLES itself.
  function automatic int unsigned cnt_width(input int unsigned stable_cycles);
    return $clog2(stable_cycles + 1);
  endfunction

endpackage

// File: rtl/mipsfpga_ahb_sevensegenc.sv
// Combinational inverse of the hex glyph set: segment pattern back to a nibble,
// flagging legal glyphs and the blank pattern.
module mipsfpga_ahb_sevensegenc
  import mipsfpga_sevenseg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       legal,
  output logic       blank
);

  always_comb begin
    nibble = 4'h0;
    legal  = 1'b1;
    blank  = 1'b0;
    case (pattern)
      SEG_0:     nibble = 4'h0;
      SEG_1:     nibble = 4'h1;
      SEG_2:     nibble = 4'h2;
      SEG_3:     nibble = 4'h3;
      SEG_4:     nibble = 4'h4;
      SEG_5:     nibble = 4'h5;
      SEG_6:     nibble = 4'h6;
      SEG_7:     nibble = 4'h7;
      SEG_8:     nibble = 4'h8;
      SEG_9:     nibble = 4'h9;
      SEG_A:     nibble = 4'hA;
      SEG_B:     nibble = 4'hB;
      SEG_C:     nibble = 4'hC;
      SEG_D:     nibble = 4'hD;
      SEG_E:     nibble = 4'hE;
      SEG_F:     nibble = 4'hF;
      SEG_BLANK: begin
        legal = 1'b0;
        blank = 1'b1;
      end
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mipsfpga_ahb_sevensegcap.sv
// Receive-side capture of a multiplexed active-low seven-segment bus.
// Define SEVENSEGCAP_SYNC_EN to add a two-flop input synchronizer (+2 cycles latency).
module mipsfpga_ahb_sevensegcap
  import mipsfpga_sevenseg_pkg::*;
#(
  parameter int unsigned NDIGITS       = 8,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic [NDIGITS-1:0]     anodes,
  input  logic [6:0]             segments,
  input  logic                   err_clr,
  output logic [4*NDIGITS-1:0]   digits,
  output logic [NDIGITS-1:0]     digit_valid,
  output logic                   frame_valid,
  output logic                   err
);

  localparam int unsigned CW = cnt_width(STABLE_CYCLES);
  localparam int unsigned SW = NDIGITS + 7;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_CAP = CW'(STABLE_CYCLES - 1);

  logic [SW-1:0]        in_v;
  logic [SW-1:0]        s_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [4*NDIGITS-1:0] digits_q, digits_d;
  logic [NDIGITS-1:0]   valid_q, valid_d;
  logic [NDIGITS-1:0]   seen_q, seen_d;
  logic                 frame_q, frame_d;
  logic                 err_q, err_d;

`ifdef SEVENSEGCAP_SYNC_EN
  logic [SW-1:0] sync1_q, sync2_q;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= {anodes, segments};
      sync2_q <= sync1_q;
    end
  end

  assign in_v = sync2_q;
`else
  assign in_v = {anodes, segments};
`endif

  logic               same;
  logic               capture;
  logic [NDIGITS-1:0] strobe;
  logic               one_hot;
  logic [NDIGITS-1:0] cap_sel;
  logic [3:0]         nibble;
  logic               legal;
  logic               blank;

  assign same    = (in_v == s_q);
  // Fires once per stable interval: the counter passes CNT_CAP exactly once before saturating.
  assign capture = same && (cnt_q == CNT_CAP);
  assign strobe  = ~s_q[SW-1:7];
  assign one_hot = (strobe != '0) && ((strobe & (strobe - NDIGITS'(1))) == '0);
  assign cap_sel = (capture && one_hot) ? strobe : '0;

  mipsfpga_ahb_sevensegenc u_enc (
    .pattern (s_q[6:0]),
    .nibble  (nibble),
    .legal   (legal),
    .blank   (blank)
  );

  always_comb begin
    cnt_d = cnt_q;
    if (!same) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_comb begin
    digits_d = digits_q;
    valid_d  = valid_q;
    err_d    = err_q;
    frame_d  = &seen_q;
    seen_d   = (&seen_q) ? '0 : seen_q;
    for (int i = 0; i < int'(NDIGITS); i++) begin
      if (cap_sel[i]) begin
        digits_d[4*i +: 4] = legal ? nibble : 4'h0;
        valid_d[i]         = legal;
      end
    end
    seen_d = seen_d | cap_sel;
    if (err_clr) begin
      err_d = 1'b0;
    end
    if ((cap_sel != '0) && !legal && !blank) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      s_q      <= '1;
      cnt_q    <= '0;
      digits_q <= '0;
      valid_q  <= '0;
      seen_q   <= '0;
      frame_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      s_q      <= in_v;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      valid_q  <= valid_d;
      seen_q   <= seen_d;
      frame_q  <= frame_d;
      err_q    <= err_d;
    end
  end

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign frame_valid = frame_q;
  assign err         = err_q;

endmodule

// File: tb/tb_mipsfpga_ahb_sevensegcap.sv
// Directed bench for mipsfpga_ahb_sevensegcap; expected output states are queued when
// stimulus is driven and popped when the capture should have landed.
module tb_mipsfpga_ahb_sevensegcap;

  localparam int unsigned ND = 8;
  localparam int unsigned SC = 4;
`ifdef SEVENSEGCAP_SYNC_EN
  localparam int LAT = SC + 2;
`else
  localparam int LAT = SC;
`endif
  // Drive happens before edge 0; capture lands on edge LAT, i.e. the (LAT+1)-th edge.
  localparam int CAP_T = LAT + 1;

  logic            HCLK = 1'b0;
  logic            HRESET;
  logic [ND-1:0]   anodes = '1;
  logic [6:0]      segments = '1;
  logic            err_clr = 1'b0;
  logic [4*ND-1:0] digits;
  logic [ND-1:0]   digit_valid;
  logic            frame_valid;
  logic            err;

  mipsfpga_ahb_sevensegcap #(
    .NDIGITS       (ND),
    .STABLE_CYCLES (SC)
  ) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .anodes      (anodes),
    .segments    (segments),
    .err_clr     (err_clr),
    .digits      (digits),
    .digit_valid (digit_valid),
    .frame_valid (frame_valid),
    .err         (err)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int errors = 0;
  int frame_cnt = 0;

  always @(negedge HCLK) if (frame_valid === 1'b1) frame_cnt++;

  typedef struct {
    string       tag;
    logic [31:0] d;
    logic [7:0]  v;
    logic        f;
    logic        e;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] md;
  logic [7:0]  mv;
  logic        me;

  function automatic logic [6:0] seg_of(input int n);
    case (n)
      0:  return 7'b000_0001;
      1:  return 7'b100_1111;
      2:  return 7'b001_0010;
      3:  return 7'b000_0110;
      4:  return 7'b100_1100;
      5:  return 7'b010_0100;
      6:  return 7'b010_0000;
      7:  return 7'b000_1111;
      8:  return 7'b000_0000;
      9:  return 7'b000_1100;
      10: return 7'b000_1000;
      11: return 7'b110_0000;
      12: return 7'b111_0010;
      13: return 7'b100_0010;
      14: return 7'b011_0000;
      default: return 7'b011_1000;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic drive(input int i, input logic [6:0] s);
    logic [7:0] a;
    a = 8'h01 << i;
    anodes = ~a;
    segments = s;
  endtask

  task automatic set_digit(input int i, input logic [3:0] nib, input logic ok);
    md[4*i +: 4] = ok ? nib : 4'h0;
    mv[i] = ok;
  endtask

  task automatic expect_now(input string tag, input logic f);
    exp_t x;
    x.tag = tag;
    x.d = md;
    x.v = mv;
    x.f = f;
    x.e = me;
    sb.push_back(x);
  endtask

  task automatic check_out();
    exp_t x;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0d required=1", sb.size());
    end else begin
      x = sb.pop_front();
      assert ({digits, digit_valid, frame_valid, err} === {x.d, x.v, x.f, x.e}) else begin
        errors++;
        $error("FAIL %s observed digits=%h valid=%h frame=%b err=%b required digits=%h valid=%h frame=%b err=%b",
               x.tag, digits, digit_valid, frame_valid, err, x.d, x.v, x.f, x.e);
      end
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int req);
    checks++;
    assert (obs == req) else begin
      errors++;
      $error("FAIL %s observed=%0d required=%0d", tag, obs, req);
    end
  endtask

  // Legal capture of value nib on digit i, checked on the capture edge.
  task automatic cap(input string tag, input int i, input int nib);
    drive(i, seg_of(nib));
    set_digit(i, 4'(nib), 1'b1);
    expect_now(tag, 1'b0);
    tick(CAP_T);
    check_out();
  endtask

  int fc0;

  initial begin
    md = '0;
    mv = '0;
    me = 1'b0;
    HRESET = 1'b0;
    #2 HRESET = 1'b1;
    tick(3);
    HRESET = 1'b0;
    expect_now("reset", 1'b0);
    check_out();

    // 1: single capture, exact latency, no repeat while held
    drive(0, seg_of(3));
    expect_now("s1_not_before", 1'b0);
    tick(LAT);
    check_out();
    set_digit(0, 4'h3, 1'b1);
    expect_now("s1_capture", 1'b0);
    tick(1);
    check_out();
    expect_now("s1_held", 1'b0);
    tick(8);
    check_out();

    // 2: glitch restarts the stability window
    drive(1, seg_of(2));
    tick(3);
    drive(1, seg_of(8));
    tick(1);
    drive(1, seg_of(2));
    expect_now("s2_not_before", 1'b0);
    tick(LAT);
    check_out();
    set_digit(1, 4'h2, 1'b1);
    expect_now("s2_capture", 1'b0);
    tick(1);
    check_out();

    // 3: full scan, one frame pulse one edge after digit 7
    fc0 = frame_cnt;
    for (int i = 0; i < 7; i++) begin
      drive(i, seg_of(i));
      set_digit(i, 4'(i), 1'b1);
      tick(5);
    end
    drive(7, seg_of(7));
    set_digit(7, 4'h7, 1'b1);
    expect_now("s3_all_digits", 1'b0);
    tick(CAP_T);
    check_out();
    check_int("s3_digits_value", int'(digits), int'(32'h7654_3210));
    expect_now("s3_frame_pulse", 1'b1);
    tick(1);
    check_out();
    expect_now("s3_frame_drop", 1'b0);
    tick(1);
    check_out();
    check_int("s3_frame_count", frame_cnt - fc0, 1);

    // 4: blank, illegal, err_clr, concurrent illegal + clear
    drive(3, 7'b111_1111);
    set_digit(3, 4'h0, 1'b0);
    expect_now("s4_blank", 1'b0);
    tick(CAP_T);
    check_out();
    drive(2, 7'b111_0000);
    set_digit(2, 4'h0, 1'b0);
    me = 1'b1;
    expect_now("s4_illegal", 1'b0);
    tick(CAP_T);
    check_out();
    err_clr = 1'b1;
    me = 1'b0;
    expect_now("s4_err_clr", 1'b0);
    tick(1);
    err_clr = 1'b0;
    check_out();
    drive(4, 7'b111_0000);
    expect_now("s4_pre_collide", 1'b0);
    tick(LAT);
    check_out();
    err_clr = 1'b1;
    set_digit(4, 4'h0, 1'b0);
    me = 1'b1;
    expect_now("s4_set_wins", 1'b0);
    tick(1);
    err_clr = 1'b0;
    check_out();

    // 5: bad strobes ignored, then reset mid-frame
    anodes = 8'hFC;
    segments = seg_of(8);
    expect_now("s5_multi_low", 1'b0);
    tick(10);
    check_out();
    anodes = 8'hFF;
    expect_now("s5_all_high", 1'b0);
    tick(10);
    check_out();
    for (int i = 0; i < 4; i++) begin
      cap("s5_prefill", i, 9 + i);
    end
    HRESET = 1'b1;
    anodes = '1;
    segments = '1;
    md = '0;
    mv = '0;
    me = 1'b0;
    #2;
    expect_now("s5_reset", 1'b0);
    check_out();
    tick(2);
    HRESET = 1'b0;
    fc0 = frame_cnt;
    cap("s5_d5", 5, 10);
    cap("s5_d6", 6, 11);
    cap("s5_d7", 7, 12);
    expect_now("s5_no_early_frame", 1'b0);
    tick(1);
    check_out();
    cap("s5_d0", 0, 13);
    cap("s5_d1", 1, 14);
    cap("s5_d2", 2, 15);
    cap("s5_d3", 3, 8);
    cap("s5_d4", 4, 9);
    expect_now("s5_frame_pulse", 1'b1);
    tick(1);
    check_out();
    check_int("s5_digits_value", int'(digits), int'(32'hCBA9_8FED));
    check_int("s5_frame_count", frame_cnt - fc0, 0);
    tick(2);
    check_int("s5_frame_count_after", frame_cnt - fc0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
